adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one 16-bit carry-lookahead adder between four requesters. Each requester issues add/subtract operations over a valid/ready handshake. A round-robin scheduler grants one operation at a time and sequences it through operand capture, execution and result hold. Per-requester carry storage lets a requester chain 16-bit operations into wider additions or subtractions. The block sits between requesting datapath units and the shared adder; results return on a single tagged response port.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- req_valid  input  N_REQ  requester i has an operation pending
- req_ready  output  N_REQ  operation of requester i accepted this cycle
- req_a  input  N_REQ×WIDTH  operand A per requester
- req_b  input  N_REQ×WIDTH  operand B per requester
- req_sub  input  N_REQ  1 = A−B, 0 = A+B
- req_chain  input  N_REQ  1 = carry-in from requester's stored carry
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  clog2(N_REQ)  requester index of result
- rsp_sum  output  WIDTH  result
- rsp_cout  output  1  carry out (subtract: 1 = no borrow)

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE to EXEC when any req_valid is set.
  - EXEC to RESP unconditionally.
  - RESP to IDLE when rsp_ready is set.
- Grant in IDLE:
  - Round-robin starting at pointer ptr: the first i in ptr, ptr+1, … (mod N_REQ) with req_valid[i] set.
  - req_ready[i] = (state==IDLE) & grant[i]. This is combinational from req_valid. Only one bit is set at a time.
  - On the handshake edge:
    - latch a, b, sub, chain and id into the operand register;
    - ptr ← (grant+1) mod N_REQ.
- EXEC:
  - b_eff = sub ? ~b : b.
  - cin = chain ? carry_q[id] : sub.
  - {cout, sum} = a + b_eff + cin, computed modulo 2^WIDTH with the carry in bit WIDTH.
  - Register sum, cout and id into the result register.
  - carry_q[id] ← cout.
- RESP:
  - rsp_valid = 1. The result register holds stable until rsp_ready.
- carry_q is written only in EXEC. A non-chained op still overwrites carry_q of its requester.
- Requesters not granted keep req_valid high. Their operands must remain stable, but the block does not check this.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, carry_q = 0;
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0.
- Latency:
  - handshake at edge t; EXEC during cycle t+1; rsp_valid high from edge t+2.
- Throughput:
  - maximum one operation per 3 cycles, with rsp_ready held high.
  - No grant while in EXEC or RESP, so backpressure stalls all requesters.
- Starvation bound: with all requesters valid, a given requester waits at most N_REQ−1 grants.
- Simultaneous events:
  - rsp_ready in RESP returns to IDLE. A new grant occurs in the next cycle, not in the same cycle.
- Reset mid-operation: the operation in flight is discarded; no response is produced; chained carries are lost.

## Structure
- Package adder_arbiter_pkg:
  - state enum (IDLE, EXEC, RESP);
  - N_REQ/WIDTH defaults;
  - the id width localparam.
- Sub-module rr_arbiter:
  - inputs: request vector and pointer;
  - outputs: one-hot grant and encoded index.
- The shared adder is instantiated as the team's 16-bit carry-lookahead adder, with carry-in driven from cin. Carry-out is derived from the top carry group, or from a WIDTH+1 sum in a behavioural model.

## Test plan
- Reset, then req0 add 0x1234+0x0FFF:
  - req_ready[0] pulses once;
  - rsp_valid two cycles later with id=0, sum=0x2233, cout=0.
- Requesters 0–3 all valid simultaneously, rsp_ready=1:
  - grant order 0,1,2,3;
  - then 0 again if still valid;
  - responses spaced 3 cycles apart.
- req2 chained 32-bit add, 0x0001_FFFF+0x0000_0001:
  - low word gives sum 0x0000, cout=1;
  - high word with chain=1 gives sum 0x0002, cout=0.
- Subtract 0x0005−0x0007:
  - sum 0xFFFE, cout=0 (borrow).
  - Chained high word 0x0000−0x0000 gives sum 0xFFFF, cout=0.
- rsp_ready held low for 10 cycles in RESP:
  - rsp_* held stable;
  - all req_ready stay 0;
  - the grant follows one cycle after rsp_ready rises.
- rst_n asserted during EXEC:
  - outputs return to reset values immediately;
  - no response is produced;
  - the next req1 chained add uses cin=0.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared types and sizing for the four-way adder arbiter.
package adder_arbiter_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_WIDTH = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_ID_W = id_width(DEF_N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cla_adder16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate.
module cla_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg    = '0;
    gp    = '0;
    gc    = '0;
    c     = '0;
    gc[0] = cin;
    for (int i = 0; i < 4; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gc[i+1]  = gg[i] | (gp[i] & gc[i]);
      c[4*i]   = gc[i];
      for (int k = 1; k < 4; k++) begin
        c[4*i+k] = g[4*i+k-1] | (p[4*i+k-1] & c[4*i+k-1]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping modulo N_REQ.
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    int unsigned pos;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(ptr) + k) % N_REQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among N_REQ requesters; round-robin grant, per-requester carry for chained ops.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0][WIDTH-1:0]  req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0]  req_b,
  input  logic [N_REQ-1:0]             req_sub,
  input  logic [N_REQ-1:0]             req_chain,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [WIDTH-1:0]             rsp_sum,
  output logic                         rsp_cout
);

  localparam int unsigned SUM_W = WIDTH + 1;

  state_e           state_q;
  state_e           state_d;
  logic [ID_W-1:0]  ptr_q;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             hs_c;
  logic             exec_c;

  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_sub_q;
  logic             op_chain_q;
  logic [ID_W-1:0]  op_id_q;
  logic [N_REQ-1:0] carry_q;

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the combinational grant strobes; ready only exposed in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    hs_c      = 1'b0;
    exec_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) begin
          hs_c    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec_c  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sub_q   <= 1'b0;
      op_chain_q <= 1'b0;
      op_id_q    <= '0;
    end else if (hs_c) begin
      op_a_q     <= req_a[grant_idx];
      op_b_q     <= req_b[grant_idx];
      op_sub_q   <= req_sub[grant_idx];
      op_chain_q <= req_chain[grant_idx];
      op_id_q    <= grant_idx;
      ptr_q      <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // Subtract is A + ~B + 1 unless a chained op borrows its stored carry instead.
  assign b_eff = op_sub_q ? ~op_b_q : op_b_q;
  assign cin   = op_chain_q ? carry_q[op_id_q] : op_sub_q;

  if (WIDTH == 16) begin : g_cla
    cla_adder16 u_cla (
      .a    (op_a_q),
      .b    (b_eff),
      .cin  (cin),
      .sum  (add_sum),
      .cout (add_cout)
    );
  end else begin : g_beh
    assign {add_cout, add_sum} = SUM_W'(op_a_q) + SUM_W'(b_eff) + SUM_W'(cin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else if (exec_c) begin
      carry_q[op_id_q] <= add_cout;
      rsp_valid        <= 1'b1;
      rsp_id           <= op_id_q;
      rsp_sum          <= add_sum;
      rsp_cout         <= add_cout;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a response scoreboard and carry model.
module tb_adder_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][W-1:0]  req_a;
  logic [N-1:0][W-1:0]  req_b;
  logic [N-1:0]         req_sub;
  logic [N-1:0]         req_chain;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [W-1:0]         rsp_sum;
  logic                 rsp_cout;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t         exp_q[$];
  int           rsp_cyc[$];
  logic [N-1:0] mcarry;
  logic [N-1:0] acc;
  int           tests;
  int           fails;
  int           cyc;

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_chain (req_chain),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge; consumed responses are scored here.
  task automatic neg();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc = req_valid & req_ready;
    check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    if (rsp_valid && rsp_ready) begin
      rsp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
      end
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    neg();
    pos();
  endtask

  task automatic drive(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic chain);
    req_valid[i] = 1'b1;
    req_a[i]     = a;
    req_b[i]     = b;
    req_sub[i]   = sub;
    req_chain[i] = chain;
  endtask

  task automatic expect_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic chain);
    logic [W:0]   r;
    logic [W-1:0] be;
    logic         ci;
    exp_t         e;
    be = sub ? ~b : b;
    ci = chain ? mcarry[i] : sub;
    r  = 17'(a) + 17'(be) + 17'(ci);
    e.id   = 2'(i);
    e.sum  = r[W-1:0];
    e.cout = r[W];
    exp_q.push_back(e);
    mcarry[i] = r[W];
  endtask

  task automatic wait_accept(input int i);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      neg();
      if (acc[i]) got = 1'b1;
      pos();
    end
    check($sformatf("accept%0d", i), 32'(got), 32'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_any(output int idx);
    idx = -1;
    for (int k = 0; k < 40 && idx < 0; k++) begin
      neg();
      for (int j = 0; j < N; j++) if (acc[j]) idx = j;
      pos();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic chain);
    drive(i, a, b, sub, chain);
    expect_op(i, a, b, sub, chain);
    wait_accept(i);
    drain();
  endtask

  initial begin
    int order [5];
    int idx;
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    mcarry    = '0;
    acc       = '0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_chain = '0;
    rsp_ready = 1'b1;

    // Reset values
    neg();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    pos();
    rst_n = 1'b1;
    tick();

    // req0 add with cycle-exact latency
    drive(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    expect_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    neg();
    check("t1_ready", 32'(req_ready), 32'h1);
    pos();
    req_valid[0] = 1'b0;
    neg();
    check("t1_exec_ready", 32'(req_ready), 32'd0);
    check("t1_exec_valid", 32'(rsp_valid), 32'd0);
    pos();
    neg();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(rsp_id), 32'd0);
    check("t1_rsp_sum", 32'(rsp_sum), 32'h2233);
    check("t1_rsp_cout", 32'(rsp_cout), 32'd0);
    pos();
    neg();
    check("t1_after_valid", 32'(rsp_valid), 32'd0);
    check("t1_after_ready", 32'(req_ready), 32'd0);
    pos();

    // req2 chained 32-bit add 0x0001_FFFF + 0x0000_0001
    single(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    single(2, 16'h0001, 16'h0000, 1'b0, 1'b1);

    // req3 chained subtract with borrow
    single(3, 16'h0005, 16'h0007, 1'b1, 1'b0);
    single(3, 16'h0000, 16'h0000, 1'b1, 1'b1);

    // All four valid; req0 re-requests after its first grant
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    rsp_cyc.delete();
    drive(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    drive(1, 16'hF000, 16'h0001, 1'b1, 1'b0);
    drive(2, 16'h8000, 16'h8000, 1'b0, 1'b0);
    drive(3, 16'h00FF, 16'hFF01, 1'b0, 1'b0);
    expect_op(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    expect_op(1, 16'hF000, 16'h0001, 1'b1, 1'b0);
    expect_op(2, 16'h8000, 16'h8000, 1'b0, 1'b0);
    expect_op(3, 16'h00FF, 16'hFF01, 1'b0, 1'b0);
    expect_op(0, 16'hABCD, 16'hABCD, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_any(idx);
      check($sformatf("rr_order%0d", k), 32'(idx), 32'(order[k]));
      if (idx < 0) req_valid = '0;
      else if (k == 0) drive(0, 16'hABCD, 16'hABCD, 1'b1, 1'b0);
      else req_valid[idx] = 1'b0;
    end
    drain();
    check("rr_rsp_count", 32'(rsp_cyc.size()), 32'd5);
    for (int k = 1; k < rsp_cyc.size(); k++)
      check($sformatf("rr_spacing%0d", k), 32'(rsp_cyc[k] - rsp_cyc[k-1]), 32'd3);

    // Backpressure: rsp_ready low for 10 cycles in RESP
    rsp_ready = 1'b0;
    drive(1, 16'h4000, 16'h0123, 1'b0, 1'b0);
    drive(0, 16'h0010, 16'h0020, 1'b1, 1'b0);
    expect_op(1, 16'h4000, 16'h0123, 1'b0, 1'b0);
    expect_op(0, 16'h0010, 16'h0020, 1'b1, 1'b0);
    neg();
    check("bp_grant1", 32'(req_ready), 32'h2);
    pos();
    req_valid[1] = 1'b0;
    neg();
    check("bp_exec_valid", 32'(rsp_valid), 32'd0);
    pos();
    for (int k = 0; k < 10; k++) begin
      neg();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_id", 32'(rsp_id), 32'd1);
      check("bp_hold_sum", 32'(rsp_sum), 32'h4123);
      check("bp_hold_cout", 32'(rsp_cout), 32'd0);
      check("bp_no_ready", 32'(req_ready), 32'd0);
      pos();
    end
    rsp_ready = 1'b1;
    neg();
    check("bp_release_no_grant", 32'(req_ready), 32'd0);
    pos();
    neg();
    check("bp_next_grant", 32'(req_ready), 32'h1);
    pos();
    req_valid[0] = 1'b0;
    drain();

    // Reset during EXEC discards the op and clears stored carries
    single(1, 16'hFFFF, 16'h0003, 1'b0, 1'b0);
    drive(1, 16'h0001, 16'h0001, 1'b0, 1'b1);
    neg();
    check("rst_mid_grant", 32'(req_ready), 32'h2);
    pos();
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_id", 32'(rsp_id), 32'd0);
    check("rst_mid_sum", 32'(rsp_sum), 32'd0);
    check("rst_mid_cout", 32'(rsp_cout), 32'd0);
    mcarry = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      neg();
      check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      pos();
    end
    single(1, 16'h0001, 16'h0001, 1'b0, 1'b1);

    // Random single ops, chained and plain, on random requesters
    for (int k = 0; k < 16; k++) begin
      single(int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
